// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and types for the writer and the VGA pixel generator.
package fb_pkg;

    localparam int IMG_W    = 256;
    localparam int IMG_H    = 256;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 16;
    localparam int FB_DEPTH = IMG_W * IMG_H;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fb_wr_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order x/y counter with a running linear address (x + W*y) kept without a multiplier.
module fb_raster_counter #(
    parameter int W  = fb_pkg::IMG_W,
    parameter int H  = fb_pkg::IMG_H,
    parameter int AW = fb_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [AW-1:0] addr_reg;

    assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);
    assign addr = addr_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x_reg    <= '0;
            y_reg    <= '0;
            addr_reg <= '0;
        end else if (inc) begin
            // Stepping past the final pixel rewinds to the origin rather than overflowing the address.
            if (last) begin
                x_reg    <= '0;
                y_reg    <= '0;
                addr_reg <= '0;
            end else begin
                addr_reg <= addr_reg + AW'(1);
                if (x_reg == X_MAX) begin
                    x_reg <= '0;
                    y_reg <= y_reg + YW'(1);
                end else begin
                    x_reg <= x_reg + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer write engine: streams one raster-order frame into the RAM write port.
// Optional running pixel checksum output is enabled by defining FB_WRITER_CHECKSUM_EN.
module fb_writer #(
    parameter int IMG_W  = fb_pkg::IMG_W,
    parameter int IMG_H  = fb_pkg::IMG_H,
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              frame_done
`ifdef FB_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]       frame_sum
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(fb_pkg::IDLE);
    localparam logic [1:0] ST_LOAD = 2'(fb_pkg::LOAD);
    localparam logic [1:0] ST_DONE = 2'(fb_pkg::DONE);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [PIX_W-1:0]  ram_data_reg;
    logic              ram_wren_reg;
    logic              frame_done_reg;

    logic              accept;
    logic              start_take;
    logic              cnt_last;
    logic [ADDR_W-1:0] cnt_addr;

    // Abort closes the handshake in the same cycle so no pixel is consumed while cancelling.
    assign s_ready    = (state_reg == ST_LOAD) && !abort;
    assign accept     = s_valid && s_ready;
    assign start_take = (state_reg == ST_IDLE) && start && !abort;
    assign busy       = (state_reg != ST_IDLE);

    fb_raster_counter #(
        .W  (IMG_W),
        .H  (IMG_H),
        .AW (ADDR_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_take),
        .inc  (accept),
        .addr (cnt_addr),
        .last (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_take) state_next = ST_LOAD;
            ST_LOAD: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (accept && cnt_last)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ram_addr_reg   <= '0;
            ram_data_reg   <= '0;
            ram_wren_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ram_wren_reg   <= accept;
            frame_done_reg <= accept && cnt_last;
            if (accept) begin
                ram_addr_reg <= cnt_addr;
                ram_data_reg <= s_data;
            end
        end
    end

    assign ram_addr   = ram_addr_reg;
    assign ram_data   = ram_data_reg;
    assign ram_wren   = ram_wren_reg;
    assign frame_done = frame_done_reg;

`ifdef FB_WRITER_CHECKSUM_EN
    logic [15:0] frame_sum_reg;

    // The sum only moves on accepted pixels, so an abort leaves it frozen.
    always_ff @(posedge clk) begin
        if (rst || start_take)
            frame_sum_reg <= '0;
        else if (accept)
            frame_sum_reg <= frame_sum_reg + 16'(s_data);
    end

    assign frame_sum = frame_sum_reg;
`endif

endmodule
